// File: rtl/icache_if.sv
// Fetch-port and memory-port bundle for the instruction cache.
// slave = cache side, master = datapath/memory side.
interface icache_if #(parameter int WORD_W = 32);
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              ihit;
  logic [WORD_W-1:0] imemload;
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache with a blocking fill FSM.
// Define ICACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module icache #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32
) (
  input  logic        CLK,
  input  logic        RST,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  typedef enum logic {IDLE, FILL} state_t;

  state_t               state_reg, state_next;
  logic [SETS-1:0]      valid_reg;
  logic [TAG_W-1:0]     tag_mem  [SETS];
  logic [WORD_W-1:0]    data_mem [SETS];
  logic [WORD_W-1:0]    miss_addr_reg, miss_addr_next;

  logic [IDX_W-1:0]     req_idx, miss_idx;
  logic [TAG_W-1:0]     req_tag, miss_tag;
  logic                 hit;
  logic                 fill_done;

  assign req_idx  = bus.imemaddr[IDX_W+1:2];
  assign req_tag  = bus.imemaddr[WORD_W-1:IDX_W+2];
  assign miss_idx = miss_addr_reg[IDX_W+1:2];
  assign miss_tag = miss_addr_reg[WORD_W-1:IDX_W+2];

  // Lookup is asynchronous so a hit returns data in the fetch cycle.
  assign hit = bus.imemREN && (state_reg == IDLE) && valid_reg[req_idx]
               && (tag_mem[req_idx] == req_tag);

  always_comb begin
    state_next     = state_reg;
    miss_addr_next = miss_addr_reg;
    bus.ihit       = 1'b0;
    bus.imemload   = '0;
    bus.iREN       = 1'b0;
    bus.iaddr      = '0;
    fill_done      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (hit) begin
          bus.ihit     = 1'b1;
          bus.imemload = data_mem[req_idx];
        end else if (bus.imemREN) begin
          miss_addr_next = bus.imemaddr & ~WORD_W'(3);
          state_next     = FILL;
        end
      end
      FILL: begin
        bus.iREN  = 1'b1;
        bus.iaddr = miss_addr_reg;
        // A redirect on imemaddr does not abort the fill; the old line lands first.
        if (!bus.iwait) begin
          fill_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      miss_addr_reg <= '0;
      valid_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      miss_addr_reg <= miss_addr_next;
      if (fill_done)
        valid_reg[miss_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && fill_done) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= bus.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_reg, miss_count_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      if (bus.ihit && hit_count_reg != 32'hFFFF_FFFF)
        hit_count_reg <= hit_count_reg + 32'd1;
      if (state_reg == IDLE && state_next == FILL && miss_count_reg != 32'hFFFF_FFFF)
        miss_count_reg <= miss_count_reg + 32'd1;
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
`endif
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios with literal expectations,
// then random fetch traffic checked every cycle against a behavioural cache model.
module tb_icache;
  localparam int SETS = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  icache_if #(.WORD_W(32)) bif ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache #(.SETS(SETS), .WORD_W(32)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bif)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return (a * 32'h9E37_79B1) + 32'h0123_4567;
  endfunction

  // Memory returns the word for whatever address the cache requests.
  always_comb bif.iload = bif.iwait ? 32'hDEAD_BEEF : mem_word(bif.iaddr);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Behavioural model: a table of cached word addresses plus one pending fill.
  bit          m_valid [SETS];
  logic [31:0] m_waddr [SETS];
  logic [31:0] m_data  [SETS];
  bit          m_busy;
  logic [31:0] m_fill_addr;
  logic [31:0] m_hits, m_misses;
  bit          chk_en = 1'b0;

  always @(negedge CLK) begin
    if (chk_en) begin
      logic [31:0] wa;
      int          idx;
      bit          e_hit;
      wa    = bif.imemaddr & ~32'd3;
      idx   = int'((wa >> 2) % SETS);
      e_hit = !m_busy && bif.imemREN && m_valid[idx] && (m_waddr[idx] == wa);
      check("ihit", {31'd0, bif.ihit}, {31'd0, e_hit});
      check("imemload", bif.imemload, e_hit ? m_data[idx] : 32'd0);
      check("iREN", {31'd0, bif.iREN}, {31'd0, m_busy});
      if (m_busy) check("iaddr", bif.iaddr, m_fill_addr);
`ifdef ICACHE_STATS_EN
      check("hit_count", hit_count, m_hits);
      check("miss_count", miss_count, m_misses);
`endif
      if (RST) begin
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
        m_busy = 1'b0; m_hits = 0; m_misses = 0;
      end else begin
        if (e_hit) m_hits++;
        if (m_busy) begin
          if (!bif.iwait) begin
            idx = int'((m_fill_addr >> 2) % SETS);
            m_valid[idx] = 1'b1;
            m_waddr[idx] = m_fill_addr;
            m_data[idx]  = mem_word(m_fill_addr);
            m_busy = 1'b0;
          end
        end else if (bif.imemREN && !e_hit) begin
          m_busy = 1'b1;
          m_fill_addr = wa;
          m_misses++;
        end
      end
    end
  end

  task automatic step(input logic rst, input logic ren, input logic [31:0] addr, input logic wt);
    @(posedge CLK);
    #1;
    RST = rst; bif.imemREN = ren; bif.imemaddr = addr; bif.iwait = wt;
    @(negedge CLK);
    #1;
  endtask

  initial begin
    bit       can_change;
    logic     ren_v;
    logic [31:0] addr_v;
    bif.imemREN = 1'b0; bif.imemaddr = '0; bif.iwait = 1'b1;
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    m_busy = 1'b0; m_fill_addr = '0; m_hits = 0; m_misses = 0;
    @(posedge CLK);
    chk_en = 1'b1;
    step(1, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1);
    check("rst_ihit", {31'd0, bif.ihit}, 32'd0);
    check("rst_iREN", {31'd0, bif.iREN}, 32'd0);
    check("rst_iaddr", bif.iaddr, 32'd0);
    check("rst_imemload", bif.imemload, 32'd0);

    // Cold miss on 0x40 with two wait cycles.
    step(0, 1, 32'h40, 1);  check("cold_detect_ihit", {31'd0, bif.ihit}, 32'd0);
    step(0, 1, 32'h40, 1);  check("cold_f1_iaddr", bif.iaddr, 32'h40);
    step(0, 1, 32'h40, 1);  check("cold_f2_iREN", {31'd0, bif.iREN}, 32'd1);
    step(0, 1, 32'h40, 0);  check("cold_f3_ihit", {31'd0, bif.ihit}, 32'd0);
    check("cold_f3_iaddr", bif.iaddr, 32'h40);
    step(0, 1, 32'h40, 1);  check("cold_ihit", {31'd0, bif.ihit}, 32'd1);
    check("cold_load", bif.imemload, 32'h8C22_0004);
    check("cold_iREN_off", {31'd0, bif.iREN}, 32'd0);
`ifdef ICACHE_STATS_EN
    check("cold_miss_count", miss_count, 32'd1);
`endif
    // Warm hit, then conflict on 0x80 evicting 0x40.
    step(0, 1, 32'h40, 1);  check("warm_ihit", {31'd0, bif.ihit}, 32'd1);
    step(0, 1, 32'h80, 1);  check("conf_miss", {31'd0, bif.ihit}, 32'd0);
    step(0, 1, 32'h80, 0);  check("conf_iaddr", bif.iaddr, 32'h80);
    step(0, 1, 32'h80, 1);  check("conf_hit", {31'd0, bif.ihit}, 32'd1);
    step(0, 1, 32'h40, 1);  check("evicted_miss", {31'd0, bif.ihit}, 32'd0);
    step(0, 1, 32'h40, 0);
    // Redirect mid-fill: 0x100 then 0x200.
    step(0, 1, 32'h100, 1);
    step(0, 1, 32'h200, 1); check("redir_iaddr", bif.iaddr, 32'h100);
    step(0, 1, 32'h200, 0); check("redir_iaddr_done", bif.iaddr, 32'h100);
    step(0, 1, 32'h200, 1); check("redir_new_miss", {31'd0, bif.ihit}, 32'd0);
    step(0, 1, 32'h200, 0); check("redir_new_iaddr", bif.iaddr, 32'h200);
    // Reset mid-fill coinciding with completion.
    step(0, 1, 32'h300, 1);
    step(1, 1, 32'h300, 0); check("rstfill_iREN", {31'd0, bif.iREN}, 32'd1);
    step(0, 1, 32'h300, 1); check("rstfill_iREN_off", {31'd0, bif.iREN}, 32'd0);
    check("rstfill_refetch_miss", {31'd0, bif.ihit}, 32'd0);
    step(0, 1, 32'h300, 0); check("rstfill_refill", bif.iaddr, 32'h300);
    // imemREN low over a valid frame.
    step(0, 0, 32'h300, 1); check("noren_ihit", {31'd0, bif.ihit}, 32'd0);
    check("noren_load", bif.imemload, 32'd0);
    step(0, 0, 32'h300, 1); check("noren_iREN", {31'd0, bif.iREN}, 32'd0);

    // Random traffic over a small address pool so hits and conflicts are frequent.
    ren_v = 1'b0; addr_v = '0;
    for (int n = 0; n < 4000; n++) begin
      can_change = bif.ihit || !bif.imemREN || (bif.iREN && ($urandom_range(0, 3) == 0));
      if (can_change) begin
        ren_v  = ($urandom_range(0, 4) != 0);
        addr_v = ($urandom_range(0, 3) << 6) | ($urandom_range(0, SETS - 1) << 2)
                 | $urandom_range(0, 3);
      end
      step(($urandom_range(0, 299) == 0), ren_v, addr_v, $urandom_range(0, 1) == 1);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
